// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Word-organised data memory with a valid/ready request port,
//            configurable wait states, size/address error reporting and
//            optional two-beat handling of word-crossing accesses.
// Config   : define DMEM_SPLIT_EN to perform word-crossing accesses as two
//            beats (ACC0 + ACC1); otherwise crossing accesses return an error.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    input  logic        req_sign,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         c_AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_WAIT_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] c_DEPTH  = 32'(DEPTH_WORDS);

`ifdef DMEM_SPLIT_EN
    localparam bit c_SPLIT_EN = 1'b1;
`else
    localparam bit c_SPLIT_EN = 1'b0;
`endif

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WAIT = 3'd1;
    localparam logic [2:0] c_ST_ACC0 = 3'd2;
    localparam logic [2:0] c_ST_ACC1 = 3'd3;
    localparam logic [2:0] c_ST_RESP = 3'd4;

    // Storage; never cleared by reset.
    logic [31:0] r_mem [DEPTH_WORDS];

    // FSM and response registers
    logic [2:0]      r_state;
    logic [3:0]      r_wait_cnt;
    logic [31:0]     r_rdata;
    logic            r_rsp_err;

    // Captured request
    logic            r_we;
    logic [1:0]      r_off;
    logic [c_AW-1:0] r_idx;
    logic [31:0]     r_wdata;
    logic [3:0]      r_bmask;
    logic            r_sign;
    logic            r_err;
    logic            r_cross;
    logic [31:0]     r_lo;

    // Accept-time decode
    logic            w_accept;
    logic            w_size_ok;
    logic [3:0]      w_span;
    logic            w_cross;
    logic [31:0]     w_idx0_full;
    logic [31:0]     w_idx1_full;
    logic            w_oob;
    logic            w_req_err;
    logic [3:0]      w_bmask;

    // Access datapath
    logic            w_in_acc1;
    logic [c_AW-1:0] w_idx_cur;
    logic [31:0]     w_rd_word;
    logic [63:0]     w_rd_cat;
    logic [31:0]     w_rd_al;
    logic [31:0]     w_rd_ext;
    logic [63:0]     w_wdata_sh;
    logic [7:0]      w_be_sh;
    logic [3:0]      w_lane_en;
    logic [31:0]     w_lane_data;
    logic            w_wr;

    assign req_ready = rst_n && (r_state == c_ST_IDLE);
    assign busy      = !req_ready;
    assign rsp_valid = (r_state == c_ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_rsp_err;
    assign w_accept  = req_valid && req_ready;

    // Decode request legality, lane mask and word-crossing from the live request fields.
    always_comb begin
        w_size_ok   = (req_size == 3'd1) || (req_size == 3'd2) || (req_size == 3'd4);
        w_span      = {2'b00, req_addr[1:0]} + {1'b0, req_size};
        w_cross     = w_size_ok && (w_span > 4'd4);
        w_idx0_full = {2'b00, req_addr[31:2]};
        w_idx1_full = w_idx0_full + 32'd1;
        w_oob       = (w_idx0_full >= c_DEPTH) || (w_cross && (w_idx1_full >= c_DEPTH));
        w_req_err   = !w_size_ok || w_oob || (w_cross && !c_SPLIT_EN);
        case (req_size)
            3'd1:    w_bmask = 4'b0001;
            3'd2:    w_bmask = 4'b0011;
            3'd4:    w_bmask = 4'b1111;
            default: w_bmask = 4'b0000;
        endcase
    end

    // Select the current word and build read alignment and write lane data.
    always_comb begin
        w_in_acc1   = (r_state == c_ST_ACC1);
        w_idx_cur   = w_in_acc1 ? (r_idx + c_AW'(1)) : r_idx;
        w_rd_word   = r_mem[w_idx_cur];
        w_rd_cat    = w_in_acc1 ? {w_rd_word, r_lo} : {32'd0, w_rd_word};
        w_rd_al     = 32'(w_rd_cat >> {r_off, 3'b000});
        case (r_bmask)
            4'b0001: w_rd_ext = {{24{r_sign & w_rd_al[7]}},  w_rd_al[7:0]};
            4'b0011: w_rd_ext = {{16{r_sign & w_rd_al[15]}}, w_rd_al[15:0]};
            default: w_rd_ext = w_rd_al;
        endcase
        w_wdata_sh  = {32'd0, r_wdata} << {r_off, 3'b000};
        w_be_sh     = {4'b0000, r_bmask} << r_off;
        w_lane_en   = w_in_acc1 ? w_be_sh[7:4] : w_be_sh[3:0];
        w_lane_data = w_in_acc1 ? w_wdata_sh[63:32] : w_wdata_sh[31:0];
        w_wr        = rst_n && r_we && ((r_state == c_ST_ACC0) || w_in_acc1);
    end

    // Byte-enable write of the selected lanes during an access beat.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_wr && w_lane_en[b]) begin
                r_mem[w_idx_cur][8*b +: 8] <= w_lane_data[8*b +: 8];
            end
        end
    end

    // Request FSM: capture, wait, one or two access beats, single-cycle response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_rdata    <= 32'd0;
            r_rsp_err  <= 1'b0;
            r_we       <= 1'b0;
            r_off      <= 2'd0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_bmask    <= 4'd0;
            r_sign     <= 1'b0;
            r_err      <= 1'b0;
            r_cross    <= 1'b0;
            r_lo       <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_off   <= req_addr[1:0];
                        r_idx   <= req_addr[c_AW+1:2];
                        r_wdata <= req_wdata;
                        r_bmask <= w_bmask;
                        r_sign  <= req_sign;
                        r_err   <= w_req_err;
                        r_cross <= w_cross;
                        if (WAIT_STATES > 0) begin
                            r_state    <= c_ST_WAIT;
                            r_wait_cnt <= c_WAIT_M1;
                        end else if (w_req_err) begin
                            r_state   <= c_ST_RESP;
                            r_rdata   <= 32'd0;
                            r_rsp_err <= 1'b1;
                        end else begin
                            r_state <= c_ST_ACC0;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        if (r_err) begin
                            r_state   <= c_ST_RESP;
                            r_rdata   <= 32'd0;
                            r_rsp_err <= 1'b1;
                        end else begin
                            r_state <= c_ST_ACC0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                c_ST_ACC0: begin
                    r_lo <= w_rd_word;
                    if (r_cross) begin
                        r_state <= c_ST_ACC1;
                    end else begin
                        r_state   <= c_ST_RESP;
                        r_rdata   <= r_we ? 32'd0 : w_rd_ext;
                        r_rsp_err <= 1'b0;
                    end
                end
                c_ST_ACC1: begin
                    r_state   <= c_ST_RESP;
                    r_rdata   <= r_we ? 32'd0 : w_rd_ext;
                    r_rsp_err <= 1'b0;
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
